// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width, PC step,
// reset address default and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; the low address bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(PC_STEP - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: a redirect target wins, otherwise step past the accepted
// instruction, otherwise keep the current fetch address.
module fetch_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_step,
  output logic [XLEN-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect) begin
      o_next_pc = align_pc(i_redirect_pc);
    end else if (i_step) begin
      o_next_pc = i_pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory request at a time and
// presents the fetched word to the IF/ID register with stall and redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            mem_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] PC_o,
  output logic [XLEN-1:0] instruc_o,
  output logic            valid_o,
  output logic            fetch_stall_o
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_advance;
  logic            w_load;
  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_pc_out;
  logic [XLEN-1:0] w_instr;
  logic            w_valid;

  assign w_advance = ~stall_i & ~mem_stall_i;
  // Ack data is captured only for a live (non-flushed) request.
  assign w_load    = (r_state == ST_WAIT) & imem_ack_i & ~redirect_i;

  fetch_pc_gen u_pc_gen (
    .i_pc          (r_pc),
    .i_redirect    (redirect_i),
    .i_redirect_pc (redirect_pc_i),
    .i_step        (w_load),
    .o_next_pc     (w_next_pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      // A new request is only issued once the presented word has been taken,
      // so an ack can never overwrite an unconsumed instruction.
      ST_REQ: begin
        if (!redirect_i && (!valid_o || w_advance)) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_i)      w_next_state = imem_ack_i ? ST_REQ : ST_DISCARD;
        else if (imem_ack_i) w_next_state = w_advance ? ST_REQ : ST_HOLD;
      end
      ST_HOLD: begin
        if (redirect_i || w_advance) w_next_state = ST_REQ;
      end
      ST_DISCARD: begin
        if (imem_ack_i) w_next_state = ST_REQ;
      end
      default: w_next_state = ST_REQ;
    endcase
  end

  always_comb begin
    w_req    = (w_next_state == ST_WAIT) || (w_next_state == ST_DISCARD);
    w_addr   = imem_addr_o;
    w_pc_out = PC_o;
    w_instr  = instruc_o;
    w_valid  = valid_o;
    if (r_state == ST_REQ && w_next_state == ST_WAIT) w_addr = r_pc;
    if (redirect_i) begin
      w_pc_out = '0;
      w_instr  = '0;
      w_valid  = 1'b0;
    end else if (w_load) begin
      w_pc_out = r_pc;
      w_instr  = imem_data_i;
      w_valid  = 1'b1;
    end else if (w_advance) begin
      w_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imem_req_o    <= 1'b0;
      imem_addr_o   <= '0;
      PC_o          <= '0;
      instruc_o     <= '0;
      valid_o       <= 1'b0;
      fetch_stall_o <= 1'b0;
    end else begin
      imem_req_o    <= w_req;
      imem_addr_o   <= w_addr;
      PC_o          <= w_pc_out;
      instruc_o     <= w_instr;
      valid_o       <= w_valid;
      fetch_stall_o <= w_req;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder plus a stream model of the expected
// instruction sequence; a monitor pops the model whenever IF/ID consumes a word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        mem_stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] PC_o;
  logic [31:0] instruc_o;
  logic        valid_o;
  logic        fetch_stall_o;

  logic        req2, ack2 = 1'b0, v2, fs2;
  logic [31:0] addr2, data2 = '0, pc2, ins2;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .PC_o(PC_o), .instruc_o(instruc_o), .valid_o(valid_o), .fetch_stall_o(fetch_stall_o)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .stall_i(1'b0), .mem_stall_i(1'b0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_data_i(data2),
    .PC_o(pc2), .instruc_o(ins2), .valid_o(v2), .fetch_stall_o(fs2)
  );

  int total = 0;
  int bad = 0;
  int consumed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  // Stream model: program order from the last restart point, word by word.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_pc;

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_t'{pc: model_pc, ins: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] start);
    exp_q.delete();
    model_pc = {start[31:2], 2'b00};
    refill();
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0) begin
        chk("stall_vs_req", 32'(fetch_stall_o), 32'(imem_req_o));
        if (valid_o && !stall_i && !mem_stall_i && !redirect_i) begin
          consumed++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got PC=%h want no instruction", PC_o);
          end else begin
            e = exp_q.pop_front();
            chk("pc_o", PC_o, e.pc);
            chk("instruc_o", instruc_o, e.ins);
            refill();
          end
        end
      end
    end
  end

  // Responder for the RESET_PC=FFFF_FFFC instance: fixed 1-cycle ack latency.
  logic [31:0] log2[$];
  bit          pend2 = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ack2  = 1'b0;
      data2 = $urandom;
      if (rst_i) begin
        pend2 = 0;
      end else if (req2 && !pend2) begin
        pend2 = 1;
        log2.push_back(addr2);
      end else if (pend2) begin
        ack2  = 1'b1;
        data2 = mem_word(addr2);
        pend2 = 0;
      end
    end
  end

  bit          pending = 0;
  int          cnt = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_log[$];
  bit          rand_mode = 0;
  bit          did_stall = 0, did_r1 = 0, did_r2 = 0;
  int          stall_left = 0;
  int          hold4 = 0, v8 = 0;

  task automatic do_cycle();
    bit          new_req;
    logic        st, ms, rd;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    if (valid_o && PC_o == 32'h4) hold4++;
    if (valid_o && PC_o == 32'h8) v8++;
    new_req     = 0;
    imem_ack_i  = 1'b0;
    imem_data_i = $urandom;
    if (imem_req_o && !pending) begin
      pending  = 1;
      cnt      = rand_mode ? int'($urandom_range(3, 1)) : 1;
      req_addr = imem_addr_o;
      req_log.push_back(imem_addr_o);
      new_req  = 1;
    end else if (pending) begin
      chk("addr_stable", imem_addr_o, req_addr);
      cnt--;
      if (cnt == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(req_addr);
        pending     = 0;
      end
    end
    st  = 1'b0;
    ms  = 1'b0;
    rd  = 1'b0;
    tgt = $urandom;
    if (rand_mode) begin
      st = ($urandom_range(3, 0) == 0);
      ms = ($urandom_range(7, 0) == 0);
      rd = ($urandom_range(19, 0) == 0);
    end else begin
      if (stall_left > 0) begin st = 1'b1; stall_left--; end
      if (imem_ack_i && req_addr == 32'h4 && !did_stall) begin
        did_stall = 1; st = 1'b1; stall_left = 2;
      end
      if (new_req && req_addr == 32'h8 && !did_r1) begin
        did_r1 = 1; rd = 1'b1; tgt = 32'h100;
      end
      if (imem_ack_i && req_addr == 32'h104 && !did_r2) begin
        did_r2 = 1; rd = 1'b1; tgt = 32'h103;
      end
    end
    stall_i       = st;
    mem_stall_i   = ms;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    if (rd) model_restart(tgt);
  endtask

  task automatic do_reset(input int n, input bit ack_junk);
    @(posedge clk);
    #1;
    rst_i = 1'b1; stall_i = 1'b0; mem_stall_i = 1'b0; redirect_i = 1'b0;
    imem_ack_i = 1'b0; pending = 0;
    repeat (n) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_restart(32'h0);
    chk("rst_pc_o", PC_o, 32'h0);
    chk("rst_instruc_o", instruc_o, 32'h0);
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_imem_req_o", 32'(imem_req_o), 32'h0);
    chk("rst_fetch_stall_o", 32'(fetch_stall_o), 32'h0);
    if (ack_junk) begin
      imem_ack_i  = 1'b1;
      imem_data_i = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    logic [31:0] exp_req[6];
    int          base;
    int          k;
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h100};

    do_reset(3, 0);
    repeat (60) do_cycle();
    chk("hold_cycles_pc4", 32'(hold4), 32'd3);
    chk("valid_pc8_cycles", 32'(v8), 32'd0);
    if (req_log.size() < 6) begin
      total++;
      bad++;
      $display("FAIL req_log_len: got=%0d want>=6", req_log.size());
    end else begin
      for (int i = 0; i < 6; i++) chk($sformatf("req_addr%0d", i), req_log[i], exp_req[i]);
    end

    rand_mode = 1;
    repeat (3000) do_cycle();
    chk("progress", 32'(consumed > 100), 32'd1);

    rand_mode = 0;
    k = 0;
    while (!pending && k < 20) begin
      do_cycle();
      k++;
    end
    chk("reach_wait", 32'(pending), 32'd1);
    base = req_log.size();
    do_reset(1, 1);
    repeat (40) do_cycle();
    if (req_log.size() > base) chk("req_after_rst", req_log[base], 32'h0);
    else chk("req_after_rst_seen", 32'(req_log.size()), 32'(base + 1));

    if (log2.size() >= 2) begin
      chk("wrap_first_req", log2[0], 32'hFFFF_FFFC);
      chk("wrap_second_req", log2[1], 32'h0);
    end else begin
      chk("wrap_req_count", 32'(log2.size()), 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
